fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// WARM/RUN/HALT control FSM with redirect, stall and halt handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    WARM = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        do_fetch;
  logic        do_jump;
  logic        do_kill;
  logic        set_merr;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WARM;
    else        state <= state_nx;
  end

  // Redirect outranks halt_req, which outranks stall.
  always_comb begin
    state_nx = state;
    do_fetch = 1'b0;
    do_jump  = 1'b0;
    do_kill  = 1'b0;
    set_merr = 1'b0;
    case (state)
      WARM: state_nx = RUN;
      RUN: begin
        if (redirect_valid) begin
          do_kill = 1'b1;
          if (redirect_target[1:0] == 2'b00) begin
            do_jump = 1'b1;
          end else begin
            set_merr = 1'b1;
            state_nx = HALT;
          end
        end else if (halt_req) begin
          do_kill  = 1'b1;
          state_nx = HALT;
        end else if (!stall) begin
          do_fetch = 1'b1;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = WARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      id_instr     <= NOP_INSTR;
      id_pc        <= 32'd0;
      id_pc4       <= 32'd0;
      id_valid     <= 1'b0;
      fetch_cnt    <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      if (do_fetch) begin
        id_instr  <= imem_rd;
        id_pc     <= pc;
        id_pc4    <= pc_plus4;
        id_valid  <= 1'b1;
        pc        <= pc_plus4;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      // A killed slot becomes a bubble; id_pc/id_pc4 keep the last real fetch.
      if (do_kill) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end
      if (do_jump)  pc           <= redirect_target;
      if (set_merr) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset and PC-wrap
// sequences, then random stimulus against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] imem_addr, imem_rd;
  logic        stall, redirect_valid, halt_req;
  logic [31:0] redirect_target;
  logic [31:0] id_instr, id_pc, id_pc4, fetch_cnt;
  logic        id_valid, halted, misalign_err;
  logic [1:0]  state_dbg;

  logic        rst_w;
  logic [31:0] imem_addr_w, imem_rd_w;
  logic        stall_w, redirect_valid_w, halt_req_w;
  logic [31:0] redirect_target_w;
  logic [31:0] id_instr_w, id_pc_w, id_pc4_w, fetch_cnt_w;
  logic        id_valid_w, halted_w, misalign_err_w;
  logic [1:0]  state_dbg_w;

  logic [31:0] mem [0:255];
  assign imem_rd   = mem[imem_addr[9:2]];
  assign imem_rd_w = mem[imem_addr_w[9:2]];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid),
    .halted(halted), .misalign_err(misalign_err), .fetch_cnt(fetch_cnt),
    .state_dbg(state_dbg)
  );

  fetch_stage #(.RESET_PC(32'hFFFFFFF8)) dut_w (
    .clk(clk), .rst_n(rst_w), .imem_addr(imem_addr_w), .imem_rd(imem_rd_w),
    .stall(stall_w), .redirect_valid(redirect_valid_w),
    .redirect_target(redirect_target_w), .halt_req(halt_req_w),
    .id_instr(id_instr_w), .id_pc(id_pc_w), .id_pc4(id_pc4_w),
    .id_valid(id_valid_w), .halted(halted_w), .misalign_err(misalign_err_w),
    .fetch_cnt(fetch_cnt_w), .state_dbg(state_dbg_w)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Behavioural model: pipeline contents as plain variables.
  logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_cnt;
  logic        m_valid, m_merr, m_warm, m_stopped;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_cnt = 0;
    m_valid = 0; m_merr = 0; m_warm = 1; m_stopped = 0;
  endtask

  task automatic model_edge();
    if (m_stopped) begin
      m_valid = 0;
    end else if (m_warm) begin
      m_warm = 0;
    end else if (redirect_valid) begin
      m_instr = NOP; m_valid = 0;
      if (redirect_target % 4 == 0) m_pc = redirect_target;
      else begin m_merr = 1; m_stopped = 1; end
    end else if (halt_req) begin
      m_instr = NOP; m_valid = 0; m_stopped = 1;
    end else if (!stall) begin
      m_instr = mem[m_pc[9:2]]; m_id_pc = m_pc; m_id_pc4 = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".id_instr"},  id_instr,  m_instr);
    chk({tag, ".id_pc"},     id_pc,     m_id_pc);
    chk({tag, ".id_pc4"},    id_pc4,    m_id_pc4);
    chk({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
    chk({tag, ".halted"},    {31'd0, halted}, {31'd0, m_stopped});
    chk({tag, ".misalign"},  {31'd0, misalign_err}, {31'd0, m_merr});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic rv, input logic [31:0] t, input logic h);
    stall = s; redirect_valid = rv; redirect_target = t; halt_req = h;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        stall, rv, halt;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_pc, e_pc4, e_instr, e_cnt;
    logic        e_valid, e_halted, e_merr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] t,
                              input logic h, input logic [31:0] a, input logic [31:0] p,
                              input logic [31:0] p4, input logic [31:0] ins,
                              input logic [31:0] c, input logic v, input logic hl,
                              input logic me);
    vec_t r;
    r.stall = s; r.rv = rv; r.tgt = t; r.halt = h;
    r.e_addr = a; r.e_pc = p; r.e_pc4 = p4; r.e_instr = ins; r.e_cnt = c;
    r.e_valid = v; r.e_halted = hl; r.e_merr = me;
    return r;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    rst_w = 1'b0;
    drive(0, 0, 0, 0);
    stall_w = 0; redirect_valid_w = 0; redirect_target_w = 0; halt_req_w = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h000000B3; mem[1] = 32'h00000233; mem[2] = 32'h00A08113;
    mem[3] = 32'h00108093; mem[8] = 32'h00500093;

    //            stall rv tgt  halt | addr  id_pc id_pc4 instr       cnt v  hlt merr
    tbl.push_back(mk(0, 0, 0,    0,    32'h00, 32'h00, 32'h00, NOP,          0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0,    32'h04, 32'h00, 32'h04, 32'h000000B3, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0,    32'h08, 32'h04, 32'h08, 32'h00000233, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0,  0,    32'h08, 32'h04, 32'h08, 32'h00000233, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0,    32'h0C, 32'h08, 32'h0C, 32'h00A08113, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0,    32'h10, 32'h0C, 32'h10, 32'h00108093, 4, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h20, 0,  32'h20, 32'h0C, 32'h10, NOP,          4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0,    32'h24, 32'h20, 32'h24, 32'h00500093, 5, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h22, 0,  32'h24, 32'h20, 32'h24, NOP,          5, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0,    1,    32'h24, 32'h20, 32'h24, NOP,          5, 0, 1, 1));
    tbl.push_back(mk(0, 1, 32'h40, 0,  32'h24, 32'h20, 32'h24, NOP,          5, 0, 1, 1));
    tbl.push_back(mk(1, 1, 32'h44, 1,  32'h24, 32'h20, 32'h24, NOP,          5, 0, 1, 1));

    // Reset values while rst_n is low.
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].rv, tbl[i].tgt, tbl[i].halt);
      tick();
      chk($sformatf("v%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.id_pc", i),     id_pc,     tbl[i].e_pc);
      chk($sformatf("v%0d.id_pc4", i),    id_pc4,    tbl[i].e_pc4);
      chk($sformatf("v%0d.id_instr", i),  id_instr,  tbl[i].e_instr);
      chk($sformatf("v%0d.fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d.id_valid", i),  {31'd0, id_valid},     {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d.halted", i),    {31'd0, halted},       {31'd0, tbl[i].e_halted});
      chk($sformatf("v%0d.misalign", i),  {31'd0, misalign_err}, {31'd0, tbl[i].e_merr});
    end

    // Asynchronous reset pulse between edges while running at PC=0x18.
    do_reset();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("async.pre_addr", imem_addr, 32'h18);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("async.warm_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("async.refetch_pc", id_pc, 32'h0);
    chk("async.refetch_valid", {31'd0, id_valid}, 32'd1);
    chk("async.refetch_instr", id_instr, 32'h000000B3);

    // PC wrap-around on an instance reset near the top of the address space.
    @(negedge clk);
    rst_w = 1'b1;
    @(posedge clk); #1;
    chk("wrap.warm_addr", imem_addr_w, 32'hFFFFFFF8);
    @(posedge clk); #1;
    chk("wrap.pc0", id_pc_w, 32'hFFFFFFF8);
    @(posedge clk); #1;
    chk("wrap.pc1", id_pc_w, 32'hFFFFFFFC);
    chk("wrap.pc4_1", id_pc4_w, 32'h00000000);
    @(posedge clk); #1;
    chk("wrap.pc2", id_pc_w, 32'h00000000);
    chk("wrap.instr2", id_instr_w, 32'h000000B3);
    chk("wrap.cnt", fetch_cnt_w, 32'd3);

    // Random stimulus against the model; reset occasionally once halted.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom_range(0, 255) * 4;
      if ($urandom_range(0, 49) == 0) t = t + $urandom_range(1, 3);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t,
            $urandom_range(0, 59) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
      if (m_stopped && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
